ifetch_ctrl: RTL and testbench

//   Instruction-fetch sequencer between the RISC-V core and the instruction ROM (word-indexed, A>>2).

---
 rtl/ifetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: sequential ROM fetch, prefetch FIFO, valid/ready delivery, redirect flush.
// Optional build macro IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module ifetch_ctrl #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [1:0]  dbg_state
);
    localparam int unsigned WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [WW-1:0] LAST = WW'(MEM_LATENCY - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    // dbg_state encoding: 0 = IDLE, 1 = FETCH, 2 = STALL
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_inst_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic          pop, at_last, slot_ok, push;

    // Handshake: a word transfers on every edge where inst_valid && inst_ready; the head
    // is held unchanged while inst_valid is high and inst_ready is low.
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    assign mem_addr   = fetch_pc_q;
    assign mem_req    = (state_q == FETCH);
    assign dbg_state  = state_q;

    always_comb begin
        pop     = inst_valid && inst_ready;
        at_last = (state_q == FETCH) && (wait_cnt_q == LAST);
        slot_ok = (count_q != FULL) || pop;
        push    = at_last && slot_ok && !redirect;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wait_cnt_d = wait_cnt_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (at_last && slot_ok) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    wait_cnt_d = '0;
                    state_d    = (count_d != FULL) ? FETCH : STALL;
                end else if (at_last) begin
                    // No room for the word: abandon this access and retry after a pop.
                    wait_cnt_d = '0;
                    state_d    = STALL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            STALL: if (pop) state_d = FETCH;
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            state_d    = FETCH;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wait_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            wait_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wait_cnt_q <= wait_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset; the head outputs are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= mem_rdata;
            fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q + (push ? 32'd1 : 32'd0);
        perf_stall_cnt_d = perf_stall_cnt_q + ((state_q == STALL) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: a MEM_LATENCY=2 and a MEM_LATENCY=1 instance share stimulus and are
// checked against a ROM-based reference (expected pc stream, rom contents) and directed timing checks.
module tb_ifetch_ctrl;
    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic [31:0] m2_addr, rd2, i2, p2;
    logic        m2_req, v2;
    logic [1:0]  st2;
    logic [31:0] m1_addr, rd1, i1, p1;
    logic        m1_req, v1;
    logic [1:0]  st1;
`ifdef IFETCH_PERF_EN
    logic [31:0] pf2, ps2, pf1, ps1;
`endif

    logic [31:0] rom [64];
    assign rd2 = rom[m2_addr[7:2]];
    assign rd1 = rom[m1_addr[7:2]];

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc2, exp_pc1;
    int          hs2 = 0, hs1 = 0;
    logic        hold2, hold1;
    logic [31:0] hp2, hi2, hp1, hi1;

    ifetch_ctrl #(.MEM_LATENCY(2), .FIFO_DEPTH(2), .RESET_PC(32'h0)) u2 (
        .clk(clk), .rst(rst), .mem_addr(m2_addr), .mem_req(m2_req), .mem_rdata(rd2),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(v2), .inst(i2),
        .inst_pc(p2), .inst_ready(inst_ready),
`ifdef IFETCH_PERF_EN
        .perf_fetch_cnt(pf2), .perf_stall_cnt(ps2),
`endif
        .dbg_state(st2)
    );

    ifetch_ctrl #(.MEM_LATENCY(1), .FIFO_DEPTH(2), .RESET_PC(32'h0)) u1 (
        .clk(clk), .rst(rst), .mem_addr(m1_addr), .mem_req(m1_req), .mem_rdata(rd1),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(v1), .inst(i1),
        .inst_pc(p1), .inst_ready(inst_ready),
`ifdef IFETCH_PERF_EN
        .perf_fetch_cnt(pf1), .perf_stall_cnt(ps1),
`endif
        .dbg_state(st1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scoreboard: each accepted word must be the next pc of the stream and the ROM word at that pc
    task automatic sb(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p,
                      inout logic [31:0] e, inout int hs);
        if (rst && v && inst_ready) begin
            chk({tag, "_pc"}, p, e);
            chk({tag, "_inst"}, i, rom[e[7:2]]);
            e  = e + 32'd4;
            hs = hs + 1;
        end
    endtask

    // one clock: score the transfer of the coming edge, update the model, then sample at negedge
    task automatic step();
        sb("u2", v2, i2, p2, exp_pc2, hs2);
        sb("u1", v1, i1, p1, exp_pc1, hs1);
        hold2 = v2 && !inst_ready && !redirect && rst;
        hold1 = v1 && !inst_ready && !redirect && rst;
        hp2 = p2; hi2 = i2; hp1 = p1; hi1 = i1;
        if (!rst) begin
            exp_pc2 = 32'h0;
            exp_pc1 = 32'h0;
        end else if (redirect) begin
            exp_pc2 = redirect_pc & ~32'h3;
            exp_pc1 = redirect_pc & ~32'h3;
        end
        @(negedge clk);
        if (hold2) begin
            chk("u2_hold_valid", 32'(v2), 32'd1);
            chk("u2_hold_pc", p2, hp2);
            chk("u2_hold_inst", i2, hi2);
        end
        if (hold1) begin
            chk("u1_hold_valid", 32'(v1), 32'd1);
            chk("u1_hold_pc", p1, hp1);
            chk("u1_hold_inst", i1, hi1);
        end
        if (!v2) chk("u2_empty_zero", i2 | p2, 32'h0);
        if (!v1) chk("u1_empty_zero", i1 | p1, 32'h0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        redirect = 1'b0;
        for (int k = 0; k < n; k++) step();
        rst = 1'b1;
    endtask

    task automatic wait_valid2(input int max_cyc);
        int n = 0;
        while (!v2 && n < max_cyc) begin
            step();
            n++;
        end
        chk("u2_wait_valid", 32'(v2), 32'd1);
    endtask

    task automatic wait_valid1(input int max_cyc);
        int n = 0;
        while (!v1 && n < max_cyc) begin
            step();
            n++;
        end
        chk("u1_wait_valid", 32'(v1), 32'd1);
    endtask

    initial begin
        int h0;
        for (int k = 0; k < 64; k++) rom[k] = $urandom;
        rom[0] = 32'h0050_0113;
        rom[1] = 32'h00C0_0193;
        rom[8] = 32'h0c40_2423;
        rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
        exp_pc2 = 32'h0; exp_pc1 = 32'h0;
        @(negedge clk);

        // reset values
        do_reset(3);
        chk("rst_addr2", m2_addr, 32'h0);
        chk("rst_req2", 32'(m2_req), 32'd0);
        chk("rst_valid2", 32'(v2), 32'd0);
        chk("rst_inst2", i2, 32'h0);
        chk("rst_pc2", p2, 32'h0);
        chk("rst_state2", 32'(st2), 32'd0);
        chk("rst_addr1", m1_addr, 32'h0);
        chk("rst_valid1", 32'(v1), 32'd0);

        // sequential fetch, each address held two cycles
        inst_ready = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            chk("seq_addr", m2_addr, 32'((n - 1) / 2 * 4));
            chk("seq_req", 32'(m2_req), 32'd1);
            if (n == 3) begin
                chk("seq_v3", 32'(v2), 32'd1);
                chk("seq_inst0", i2, 32'h0050_0113);
                chk("seq_pc0", p2, 32'h0);
            end
            if (n == 4) chk("seq_v4", 32'(v2), 32'd0);
            if (n == 5) begin
                chk("seq_inst1", i2, 32'h00C0_0193);
                chk("seq_pc1", p2, 32'h4);
            end
        end

        // redirect mid-access
        chk("redir_midaccess", 32'(m2_req), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h23;
        step();
        redirect = 1'b0;
        chk("redir_valid2", 32'(v2), 32'd0);
        chk("redir_addr2", m2_addr, 32'h20);
        chk("redir_valid1", 32'(v1), 32'd0);
        chk("redir_addr1", m1_addr, 32'h20);
        wait_valid2(10);
        chk("redir_pc", p2, 32'h20);
        chk("redir_inst", i2, 32'h0c40_2423);
        for (int k = 0; k < 6; k++) step();

        // backpressure fills the FIFO and stalls fetch
        do_reset(2);
        inst_ready = 1'b0;
        for (int n = 1; n <= 12; n++) step();
        chk("bp_state", 32'(st2), 32'd2);
        chk("bp_req", 32'(m2_req), 32'd0);
        chk("bp_valid", 32'(v2), 32'd1);
        chk("bp_inst", i2, 32'h0050_0113);
        chk("bp_pc", p2, 32'h0);
        chk("bp_addr", m2_addr, 32'h8);
`ifdef IFETCH_PERF_EN
        chk("perf_fetch", pf2, 32'd2);
        chk("perf_stall", ps2, 32'd7);
`endif
        inst_ready = 1'b1;
        h0 = hs2;
        for (int k = 0; k < 12; k++) step();
        chk("bp_drain_cnt", 32'(hs2 - h0 >= 5), 32'd1);

        // MEM_LATENCY=1 sustains one word per cycle
        do_reset(2);
        inst_ready = 1'b1;
        wait_valid1(5);
        chk("thr_first_pc", p1, 32'h0);
        h0 = hs1;
        for (int k = 0; k < 14; k++) begin
            chk("thr_valid", 32'(v1), 32'd1);
            step();
        end
        chk("thr_count", 32'(hs1 - h0), 32'd14);
        chk("thr_next_pc", exp_pc1, 32'h38);

        // reset in the middle of an access
        do_reset(2);
        step();
        step();
        chk("mid_state", 32'(st2), 32'd1);
        rst = 1'b0;
        step();
        chk("mid_addr", m2_addr, 32'h0);
        chk("mid_req", 32'(m2_req), 32'd0);
        chk("mid_valid", 32'(v2), 32'd0);
        chk("mid_inst", i2, 32'h0);
        chk("mid_pc", p2, 32'h0);
        chk("mid_st", 32'(st2), 32'd0);
        rst = 1'b1;
        step();
        step();
        chk("mid_restart_addr", m2_addr, 32'h0);
        chk("mid_restart_req", 32'(m2_req), 32'd1);
        for (int k = 0; k < 6; k++) step();

        // fetch_pc wraps past the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        step();
        redirect = 1'b0;
        chk("wrap_addr", m2_addr, 32'hFFFF_FFF8);
        h0 = hs2;
        for (int k = 0; k < 12; k++) step();
        chk("wrap_cnt", 32'(hs2 - h0 >= 4), 32'd1);
        chk("wrap_exp", 32'(exp_pc2 < 32'h100), 32'd1);

        // random ready / redirect / reset traffic
        for (int k = 0; k < 400; k++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = $urandom_range(0, 255);
            rst         = ($urandom_range(0, 99) != 0);
            step();
        end
        rst = 1'b1; redirect = 1'b0; inst_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
